// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared integer-core widths and register-file types
//
// Purpose: default data width and register count for the integer core,
//          plus the word and register-index types built from them.
// Contents:
//    CPU_XLEN   default data width in bits
//    CPU_NREG   default number of architectural registers (power of two)
//    CPU_AW     register index width derived from CPU_NREG
//    word_t     one data word
//    reg_idx_t  one register index
package cpu_pkg;

   localparam int CPU_XLEN = 32;
   localparam int CPU_NREG = 32;
   localparam int CPU_AW   = $clog2(CPU_NREG);

   typedef logic [CPU_XLEN-1:0] word_t;
   typedef logic [CPU_AW-1:0]   reg_idx_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - busy-bit scoreboard for register-file producers
//
// Purpose: one busy bit per architectural register. A bit is set when an
//          instruction that will write that register issues, and cleared
//          when its result is written back or when the pipeline flushes.
// Ports:
//    clk        in   1          clock, state updates on rising edge
//    rst_n      in   1          asynchronous active-low reset, clears all bits
//    iss_valid  in   1          an instruction with a destination issues
//    iss_rd     in   AW         destination of the issuing instruction
//    wr_en      in   NWR        write-back enables
//    wr_addr    in   NWR*AW     write-back addresses, port w = [w*AW +: AW]
//    flush      in   1          clear every busy bit
//    busy_vec   out  NREG       current busy bits, bit 0 always 0
module rf_scoreboard
   import cpu_pkg::*;
#(
   parameter int NREG = CPU_NREG,
   parameter int NWR  = 1,
   parameter int AW   = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              iss_valid,
   input  logic [AW-1:0]     iss_rd,
   input  logic [NWR-1:0]    wr_en,
   input  logic [NWR*AW-1:0] wr_addr,
   input  logic              flush,
   output logic [NREG-1:0]   busy_vec
);

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;

   // The checks are applied lowest priority first so that later assignments
   // override: write-back clear, then issue set (the newer producer), then
   // flush, which beats everything.
   always_comb begin
      busy_nxt = busy;
      for (int r = 1; r < NREG; r++) begin
         for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] == AW'(r))) begin
               busy_nxt[r] = 1'b0;
            end
         end
         if (iss_valid && (iss_rd == AW'(r))) begin
            busy_nxt[r] = 1'b1;
         end
         if (flush) begin
            busy_nxt[r] = 1'b0;
         end
      end
      // x0 has no producer to wait for.
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   assign busy_vec = busy;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port integer register file with bypass and scoreboard
//
// Purpose: ID-stage register file. NRD combinational read ports, NWR write
//          ports from WB with same-cycle write-to-read bypass, x0 hard-wired
//          to zero, and a busy-bit scoreboard that marks reads whose
//          producer has not written back yet.
// Ports:
//    clk        in   1          clock, state updates on rising edge
//    rst_n      in   1          asynchronous active-low reset
//    rd_addr    in   NRD*AW     read addresses, port p = [p*AW +: AW]
//    rd_data    out  NRD*XLEN   read data including bypass
//    rd_ready   out  NRD        1 = rd_data may be consumed this cycle
//    wr_en      in   NWR        write enables
//    wr_addr    in   NWR*AW     write addresses
//    wr_data    in   NWR*XLEN   write data
//    iss_valid  in   1          an instruction with a destination issues
//    iss_rd     in   AW         its destination register
//    flush      in   1          clear every busy bit
//    busy_vec   out  NREG       scoreboard state, bit 0 always 0
module regfile_mp
   import cpu_pkg::*;
#(
   parameter int XLEN = CPU_XLEN,
   parameter int NREG = CPU_NREG,
   parameter int NRD  = 2,
   parameter int NWR  = 1,
   parameter int AW   = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_ready,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                iss_valid,
   input  logic [AW-1:0]       iss_rd,
   input  logic                flush,
   output logic [NREG-1:0]     busy_vec
);

   logic [XLEN-1:0] regs [NREG];

   // Writes are applied in ascending port order, so when two ports target
   // the same register the last non-blocking assignment (highest index) wins.
   // x0 is never written and therefore keeps its reset value of zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) begin
            regs[r] <= '0;
         end
      end else begin
         for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
               regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
            end
         end
      end
   end

   rf_scoreboard #(
      .NREG (NREG),
      .NWR  (NWR),
      .AW   (AW)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .flush     (flush),
      .busy_vec  (busy_vec)
   );

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      logic            ready;

      assign addr = rd_addr[p*AW +: AW];

      always_comb begin
         data  = regs[addr];
         ready = !busy_vec[addr];
         // A matching write port supplies the value that is about to be
         // stored; it also resolves the pending producer, so ready is 1.
         for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] == addr)) begin
               data  = wr_data[w*XLEN +: XLEN];
               ready = 1'b1;
            end
         end
         // x0 and the in-reset state override any bypass: writes presented
         // during reset are lost, so they must not leak out through the bypass.
         if ((addr == '0) || !rst_n) begin
            data  = '0;
            ready = 1'b1;
         end
      end

      assign rd_data[p*XLEN +: XLEN] = data;
      assign rd_ready[p]             = ready;
   end

endmodule
